pwm_peripheral: RTL and testbench
=================================

// Module: pwm_peripheral
// PURPOSE
//   Consumes the five 8-bit control registers from the SPI register block.
//   Drives 16 output pins: forced low, forced high, or PWM-modulated.
//   One shared 8-bit PWM counter runs from a clock prescaler.
//   Duty cycle is double-buffered, so a period is never glitched mid-way.
//   Sits directly downstream of the SPI register block; its outputs go to the chip pins.
// PARAMETERS
//   CLK_DIV   13   Prescaler ratio, clk cycles per PWM count; legal >= 1 (10 MHz/(13*256) ~ 3 kHz).
//   CNT_W     8    PWM counter width; fixed at 8 to match the pwm_duty_cycle width.
// PORTS
//   clk              in   1   System clock; sole clock domain (one clock).
//   rst              in   1   Reset; synchronous, active-high.
//   en_reg_out_7_0   in   8   Output enable, pins 7..0 (1 = pin driven per PWM enable, 0 = pin low).
//   en_reg_out_15_8  in   8   Output enable, pins 15..8.
//   en_reg_pwm_7_0   in   8   PWM select, pins 7..0 (1 = PWM waveform, 0 = static high).
//   en_reg_pwm_15_8  in   8   PWM select, pins 15..8.
//   pwm_duty_cycle   in   8   Duty cycle; high time = duty/256 of the period; 0xFF = 100 %.
//   out              out  16  Pin outputs, registered.
//   period_start     out  1   One-cycle pulse when the counter wraps 255 -> 0 (new shadow duty in force).
// BEHAVIOUR
//   Reset (rst=1 at posedge clk), all of these clear on that edge:
//     prescaler=0, pwm_cnt=0, duty_shadow=0, out=16'h0000, period_start=0.
//   Prescaler:
//     counts 0..CLK_DIV-1, then wraps to 0.
//     tick=1 in the cycle where prescaler==CLK_DIV-1.
//     CLK_DIV=1 gives tick=1 every cycle.
//   PWM counter:
//     pwm_cnt increments on tick only; wraps 255 -> 0.
//     Period = 256*CLK_DIV clk cycles.
//   Duty shadow:
//     On tick with pwm_cnt==255, duty_shadow <= pwm_duty_cycle, sampled in that same cycle.
//     period_start <= 1 on that same edge, so it is high for the first cycle of pwm_cnt==0.
//     A duty change at any other time has no effect until the next wrap.
//   PWM signal (combinational):
//     pwm_sig = (duty_shadow==8'hFF) ? 1 : (pwm_cnt < duty_shadow).
//     duty 0x00 gives constant 0; 0x80 gives 128/256 high; 0xFF gives constant 1.
//   Output, per pin i, registered; one clk of latency from any enable change:
//     out[i] <= en_out[i] ? (en_pwm[i] ? pwm_sig : 1'b1) : 1'b0.
//     en_out / en_pwm are the {15_8, 7_0} concatenations.
//   Inputs come from registers in the same clk domain, so no synchronisers.
//   Enables take effect immediately; they are not double-buffered.
//   Reset mid-period: counter and shadow restart from 0.
//     After release, PWM pins stay low until the first wrap loads duty_shadow.
//     That is 256*CLK_DIV cycles.
//   Simultaneous wrap and duty write: the value present on the wrap edge is the one loaded.
// STRUCTURE
//   Package pwm_pkg:
//     PWM_CNT_W=8, DUTY_FULL=8'hFF, PWM_CLK_DIV_DEFAULT=13, NUM_PINS=16.
//   Sub-module pwm_timebase (prescaler + pwm_cnt):
//     inputs: clk, rst.
//     outputs: tick, pwm_cnt[7:0], wrap (= tick && pwm_cnt==255).
//   Top level: duty_shadow register, compare, 16-bit output mux/register, period_start flop.
// TESTING
//   1. Reset: hold rst 3 cycles with all inputs 0xFF -> out==0 and period_start==0 during reset.
//      After release, period_start first pulses 256*CLK_DIV cycles later.
//   2. Static: en_out=16'hFFFF, en_pwm=0 -> out==16'hFFFF one clk after the enables change;
//      en_out=16'h00F0 -> out==16'h00F0.
//   3. Duty sweep, en_out=en_pwm=16'hFFFF, CLK_DIV=13:
//      duty 0x00 -> out constant 0.
//      duty 0x80 -> 1664 high / 1664 low cycles per 3328-cycle period.
//      duty 0xFF -> constant 0xFFFF.
//   4. Glitch-free update: change duty 0x40 -> 0xC0 at pwm_cnt==0x60.
//      Current period keeps 0x40 high time (64*13 cycles).
//      Next period, after period_start, has 0xC0 high time (192*13 cycles).
//   5. Mixed pins: en_out=16'hA5A5, en_pwm=16'h0F0F, duty 0x40 ->
//      PWM on pins in A5A5 & 0F0F; static high on pins in A5A5 & ~0F0F; all others 0.
//   6. Mid-period reset: assert rst at pwm_cnt==100 -> next cycle out==0 and pwm_cnt==0;
//      duty reloads only at the next wrap. Repeat test 3 with CLK_DIV=1 (period = 256 cycles).

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, constants and compare helper for the PWM peripheral.
package pwm_pkg;
    localparam int PWM_CNT_W = 8;
    localparam int PWM_CLK_DIV_DEFAULT = 13;
    localparam int NUM_PINS = 16;
    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
    localparam logic [PWM_CNT_W-1:0] CNT_MAX = 8'hFF;
    typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;
    typedef logic [NUM_PINS-1:0] pin_vec_t;
    // Full-scale duty is forced high so 0xFF really means 100 %, not 255/256.
    function automatic logic pwm_compare(input pwm_cnt_t cnt, input pwm_cnt_t duty);
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction
endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: clock prescaler and shared free-running PWM counter.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    output logic     tick,
    output pwm_cnt_t pwm_cnt,
    output logic     wrap
);
    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);
    logic [PRE_W-1:0] r_pre;
    pwm_cnt_t         r_cnt;
    always_comb begin
        tick    = (r_pre == PRE_MAX);
        wrap    = tick && (r_cnt == CNT_MAX);
        pwm_cnt = r_cnt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else begin
            r_pre <= tick ? '0 : r_pre + 1'b1;
            r_cnt <= tick ? r_cnt + 1'b1 : r_cnt;
        end
    end
endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16 pins driven low, high or from a shared PWM compare;
// duty is taken into a shadow register only at the counter wrap.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT,
    parameter int CNT_W   = PWM_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);
    logic             w_tick;
    logic             w_wrap;
    pwm_cnt_t         w_pwm_cnt;
    logic             w_pwm_sig;
    pin_vec_t         w_en_out;
    pin_vec_t         w_en_pwm;
    pin_vec_t         w_out_nxt;
    logic [CNT_W-1:0] r_duty_shadow;
    pwm_timebase #(.CLK_DIV(CLK_DIV)) u_timebase (
        .clk     (clk),
        .rst     (rst),
        .tick    (w_tick),
        .pwm_cnt (w_pwm_cnt),
        .wrap    (w_wrap)
    );
    always_comb begin
        w_en_out  = {en_reg_out_15_8, en_reg_out_7_0};
        w_en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        w_pwm_sig = pwm_compare(w_pwm_cnt, r_duty_shadow);
        w_out_nxt = w_en_out & (~w_en_pwm | {NUM_PINS{w_pwm_sig}});
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty_shadow <= '0;
            out           <= '0;
            period_start  <= 1'b0;
        end else begin
            r_duty_shadow <= w_wrap ? pwm_duty_cycle : r_duty_shadow;
            out           <= w_out_nxt;
            period_start  <= w_wrap;
        end
    end
    a_wrap_on_tick: assert property (@(posedge clk) w_wrap |-> w_tick);
endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: directed checks of reset, static pins, duty sweep,
// glitch-free duty update, mixed pins and mid-period reset.
module tb_pwm_peripheral;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    logic [15:0] out13, out1;
    logic        ps13, ps1;
    logic        sel;
    logic [15:0] w_out;
    logic        w_ps;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n, hi, bad;
    always #5 clk = ~clk;
    pwm_peripheral #(.CLK_DIV(13)) dut13 (
        .clk(clk), .rst(rst),
        .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
        .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
        .pwm_duty_cycle(duty), .out(out13), .period_start(ps13)
    );
    pwm_peripheral #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst),
        .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
        .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
        .pwm_duty_cycle(duty), .out(out1), .period_start(ps1)
    );
    assign w_out = sel ? out1 : out13;
    assign w_ps  = sel ? ps1 : ps13;
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask
    // Leaves the bench on the negedge of the period_start cycle.
    task automatic wait_ps(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!w_ps && cnt < 4000);
        if (!w_ps) check("ps_timeout", 0, 1);
    endtask
    // Samples one full period starting at the period_start cycle.
    task automatic measure(input int len, input int chg_at, input logic [7:0] chg_val,
                           output int n_hi, output int n_bad);
        n_hi = 0;
        n_bad = 0;
        for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge clk);
            if (c == chg_at) duty = chg_val;
            if (w_out == 16'hFFFF) n_hi++;
            else if (w_out != 16'h0000) n_bad++;
        end
    endtask
    task automatic sweep(input string tag, input logic [7:0] d, input int per, input int exp_hi);
        duty = d;
        wait_ps(n);
        wait_ps(n);
        check({tag, "_period"}, n, per);
        measure(per, -1, 8'h00, hi, bad);
        check({tag, "_high"}, hi, exp_hi);
        check({tag, "_bad"}, bad, 0);
    endtask
    initial begin
        sel = 1'b0;
        rst = 1'b1;
        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        duty = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_out", w_out, 0);
            check("rst_ps", w_ps, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_out", w_out, 0);
        wait_ps(n);
        check("first_ps", n + 1, 3328);
        check("ps_cycle_out", w_out, 16'h0000);
        @(negedge clk);
        check("full_after_ps", w_out, 16'hFFFF);
        en_pwm = 16'h0000;
        @(negedge clk);
        check("static_all", w_out, 16'hFFFF);
        en_out = 16'h00F0;
        @(negedge clk);
        check("static_00f0", w_out, 16'h00F0);
        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        sweep("d00", 8'h00, 3328, 0);
        sweep("d80", 8'h80, 3328, 1664);
        sweep("dff", 8'hFF, 3328, 3328);
        duty = 8'h40;
        wait_ps(n);
        wait_ps(n);
        measure(3328, 96 * 13, 8'hC0, hi, bad);
        check("glitch_cur_high", hi, 64 * 13);
        check("glitch_cur_bad", bad, 0);
        @(negedge clk);
        check("glitch_ps", w_ps, 1);
        measure(3328, -1, 8'h00, hi, bad);
        check("glitch_next_high", hi, 192 * 13);
        en_out = 16'hA5A5;
        en_pwm = 16'h0F0F;
        duty = 8'h40;
        wait_ps(n);
        wait_ps(n);
        check("mix_ps_cycle", w_out, 16'hA0A0);
        repeat (10) @(negedge clk);
        check("mix_high", w_out, 16'hA5A5);
        repeat (822) @(negedge clk);
        check("mix_last_high", w_out, 16'hA5A5);
        @(negedge clk);
        check("mix_low", w_out, 16'hA0A0);
        repeat (1300 - 833) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out", w_out, 0);
        check("midrst_ps", w_ps, 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_static", w_out, 16'hA0A0);
        wait_ps(n);
        check("midrst_reload", n + 1, 3328);
        @(negedge clk);
        check("midrst_duty", w_out, 16'hA5A5);
        sel = 1'b1;
        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        sweep("div1_d00", 8'h00, 256, 0);
        sweep("div1_d80", 8'h80, 256, 128);
        sweep("div1_dff", 8'hFF, 256, 256);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
